// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, frame constants
// and the odd-parity helper used by both transmit and receive paths.
package ps2_pkg;

  localparam int unsigned PS2_DATA_BITS = 8;
  localparam int unsigned PS2_STOP_EDGE = 9;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    WAIT_ACK,
    WAIT_IDLE
  } ps2_state_e;

  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a falling-edge
// detector on the synchronized clock.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall_c
);

  logic clk_meta;
  logic data_meta;
  logic clk_prev;

  // Reset to the idle (pulled-up) level so leaving reset never looks like an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
      clk_prev  <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data;
      data_sync <= data_meta;
      clk_prev  <= clk_sync;
    end
  end

  assign clk_fall_c = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter: clock inhibit, request-to-send, 11-bit
// frame clocked by the device, ACK check and bus-idle wait with a watchdog.
module ps2_transmitter
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned INH_W   = $clog2(INHIBIT_CYCLES) + 1;
  localparam int unsigned WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned BIT_W   = $clog2(PS2_STOP_EDGE + 1);
  localparam int unsigned SHIFT_W = PS2_DATA_BITS + 1;

  logic clk_sync;
  logic data_sync;
  logic clk_fall;

  ps2_sync_edge u_sync (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .clk_sync   (clk_sync),
    .data_sync  (data_sync),
    .clk_fall_c (clk_fall)
  );

  ps2_state_e         state_q, state_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
  logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
  logic               clk_oe_d, data_oe_d, busy_d, done_d, error_d;
  logic               timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      inh_cnt_q   <= '0;
      wd_cnt_q    <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      inh_cnt_q   <= inh_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
      tx_busy     <= busy_d;
      tx_done     <= done_d;
      tx_error    <= error_d;
    end
  end

  // Watchdog expires only when no device edge arrives in this cycle
  assign timeout = ~clk_fall && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    wd_cnt_d  = wd_cnt_q;
    clk_oe_d  = ps2_clk_oe;
    data_oe_d = ps2_data_oe;
    busy_d    = tx_busy;
    done_d    = 1'b0;
    error_d   = 1'b0;

    if (state_q == SEND || state_q == WAIT_ACK || state_q == WAIT_IDLE) begin
      wd_cnt_d = clk_fall ? '0 : wd_cnt_q + WD_W'(1);
    end

    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_start) begin
          shift_d   = {odd_parity(tx_data), tx_data};
          busy_d    = 1'b1;
          clk_oe_d  = 1'b1;
          inh_cnt_d = '0;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        inh_cnt_d = inh_cnt_q + INH_W'(1);
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          data_oe_d = 1'b1;
          state_d   = RTS;
        end
      end
      RTS: begin
        // Start bit is already low; handing the clock to the device
        clk_oe_d  = 1'b0;
        bit_cnt_d = '0;
        wd_cnt_d  = '0;
        state_d   = SEND;
      end
      SEND: begin
        if (clk_fall) begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(PS2_STOP_EDGE)) begin
            data_oe_d = 1'b0;
            state_d   = WAIT_ACK;
          end else begin
            data_oe_d = ~shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      WAIT_ACK: begin
        if (clk_fall) begin
          if (!data_sync) begin
            state_d = WAIT_IDLE;
          end else begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout && (state_q == SEND || state_q == WAIT_ACK ||
                    (state_q == WAIT_IDLE && !(clk_sync && data_sync)))) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      error_d   = 1'b1;
      busy_d    = 1'b0;
      state_d   = IDLE;
    end
  end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: open-drain bus with a behavioural PS/2 device that
// clocks the frame, samples on rising edges and optionally ACKs.
module tb_ps2_transmitter;

  localparam int unsigned INH  = 20;
  localparam int unsigned TMO  = 2000;
  localparam int          HALF = 30;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_error;
  logic       dev_clk_low, dev_data_low;
  logic       clk_line, data_line;

  assign clk_line  = ~(ps2_clk_oe  | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (clk_line),
    .ps2_data    (data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0, err_cnt = 0, err_cyc = 0, fall_cyc = 0;
  int overlap_cnt = 0, long_pulse_cnt = 0, busy_on_end_cnt = 0;
  logic prev_done = 1'b0, prev_err = 1'b0;

  always @(posedge clk) cyc++;

  // Pulse bookkeeping sampled away from the active edge
  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_error) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (tx_done && tx_error) overlap_cnt++;
    if ((tx_done && prev_done) || (tx_error && prev_err)) long_pulse_cnt++;
    if ((tx_done || tx_error) && tx_busy) busy_on_end_cnt++;
    prev_done = tx_done;
    prev_err  = tx_error;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Frame as the device should see it: {stop, odd parity, data LSB-first, start}
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic start_frame(input logic [7:0] d, output int inh_n, output int rts_n,
                             output int lat);
    @(negedge clk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    lat = 1; inh_n = 0; rts_n = 0;
    for (int i = 0; i < 200; i++) begin
      if (ps2_clk_oe && !ps2_data_oe) inh_n++;
      else if (ps2_clk_oe && ps2_data_oe) rts_n++;
      else break;
      @(negedge clk);
      lat++;
    end
  endtask

  // Device side: issues n_falls clock pulses, samples on rising edges
  task automatic device_run(input int n_falls, input bit ack, output logic [10:0] bits);
    bits    = '1;
    bits[0] = data_line;
    for (int k = 1; k <= n_falls; k++) begin
      if (k == 11 && ack) begin
        dev_data_low = 1'b1;
        repeat (5) @(negedge clk);
      end
      @(negedge clk);
      dev_clk_low = 1'b1;
      fall_cyc    = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) bits[k] = data_line;
      repeat (HALF) @(negedge clk);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic do_frame(input logic [7:0] d, input string tag);
    int inh_n, rts_n, lat, d0, e0;
    logic [10:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    start_frame(d, inh_n, rts_n, lat);
    check({tag, "_inhibit"}, 32'(inh_n), 32'(INH));
    check({tag, "_rts"}, 32'(rts_n), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(INH + 2));
    device_run(11, 1'b1, bits);
    repeat (20) @(negedge clk);
    check({tag, "_frame"}, 32'(bits), 32'(exp_frame(d)));
    check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_noerr"}, 32'(err_cnt - e0), 32'd0);
    check({tag, "_idle"}, {29'd0, tx_busy, ps2_clk_oe, ps2_data_oe}, 32'd0);
  endtask

  initial begin
    int inh_n, rts_n, lat, d0, e0, waited;
    logic [10:0] bits;
    logic [7:0] d;
    rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {27'd0, ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_error}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Nominal frames, including both parity polarities
    do_frame(8'hF4, "f4");
    do_frame(8'hFF, "ff");
    check("ff_parity_one", 32'(exp_frame(8'hFF) >> 9 & 11'd1), 32'd1);

    // Device never drives ACK on the 11th falling edge
    d0 = done_cnt; e0 = err_cnt;
    d = 8'($urandom_range(0, 255));
    start_frame(d, inh_n, rts_n, lat);
    device_run(11, 1'b0, bits);
    repeat (20) @(negedge clk);
    check("nack_frame", 32'(bits[9:0]), 32'(exp_frame(d) & 11'h3FF));
    check("nack_error", 32'(err_cnt - e0), 32'd1);
    check("nack_nodone", 32'(done_cnt - d0), 32'd0);
    check("nack_released", {29'd0, tx_busy, ps2_clk_oe, ps2_data_oe}, 32'd0);

    // Device stalls after 4 edges: pin fall reaches clk_fall 3 edges later
    d0 = done_cnt; e0 = err_cnt;
    start_frame(8'hA5, inh_n, rts_n, lat);
    device_run(4, 1'b0, bits);
    waited = 0;
    while (err_cnt == e0 && waited < TMO + 200) begin
      @(negedge clk);
      waited++;
    end
    check("timeout_error", 32'(err_cnt - e0), 32'd1);
    check("timeout_latency", 32'(err_cyc - fall_cyc), 32'(TMO + 3));
    check("timeout_released", {29'd0, tx_busy, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("timeout_nodone", 32'(done_cnt - d0), 32'd0);

    // Second tx_start while busy must be ignored
    d0 = done_cnt;
    start_frame(8'hED, inh_n, rts_n, lat);
    fork
      device_run(11, 1'b1, bits);
      begin
        repeat (150) @(negedge clk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    check("busy_ignore_frame", 32'(bits), 32'(exp_frame(8'hED)));
    check("busy_ignore_done", 32'(done_cnt - d0), 32'd1);
    repeat (100) @(negedge clk);
    check("busy_ignore_norestart", {30'd0, tx_busy, ps2_clk_oe}, 32'd0);

    // Reset while bit 5 (a zero in 0xC3) is on the wire
    d0 = done_cnt; e0 = err_cnt;
    start_frame(8'hC3, inh_n, rts_n, lat);
    device_run(6, 1'b0, bits);
    check("pre_reset_bit5", {30'd0, tx_busy, ps2_data_oe}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_abort", {29'd0, tx_busy, ps2_clk_oe, ps2_data_oe}, 32'd0);
    repeat (10) @(negedge clk);
    check("reset_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    do_frame(8'hF4, "post_reset");

    for (int i = 0; i < 5; i++) do_frame(8'($urandom_range(0, 255)), "rand");

    check("done_error_overlap", 32'(overlap_cnt), 32'd0);
    check("pulse_width", 32'(long_pulse_cnt), 32'd0);
    check("busy_drop_with_pulse", 32'(busy_on_end_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
